// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Control FSM for the multi-cycle MIPS-subset datapath. It walks each
// instruction through IF -> ID -> EX -> (MEM) -> (WB) and drives every
// write-enable and mux select of the datapath. Instructions take 2 to 5 clocks.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous, active-high reset
//   Inst_code  in   IR contents (meaningful from ID onward)
//   ZF         in   ALU zero flag (combinational from the datapath)
//   OF         in   ALU signed-overflow flag
//   PC_Write   out  PC load enable
//   PC_s       out  PC source: 00 PC+4, 01 branch target, 10 jump target
//   IR_Write   out  IR load enable
//   Write_Reg  out  register-file write enable
//   Mem_Write  out  data-memory write enable
//   ALU_OP     out  000 AND, 001 OR, 010 XOR, 011 NOR,
//                   100 ADD, 101 SUB, 110 SLTU, 111 SLL
//   rd_rt_s    out  1 = rt is the write address, 0 = rd
//   imm_s      out  1 = sign-extend imm16, 0 = zero-extend
//   rt_imm_s   out  1 = ALU B operand is the immediate, 0 = rt data
//   alu_mem_s  out  1 = write-back data from memory, 0 = from the ALU register
//   state      out  current state encoding (debug)
//   illegal    out  one-cycle pulse in ID on an undecodable instruction
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     Inst_code,
    input  logic            ZF,
    input  logic            OF,
    output logic            PC_Write,
    output logic [1:0]      PC_s,
    output logic            IR_Write,
    output logic            Write_Reg,
    output logic            Mem_Write,
    output logic [2:0]      ALU_OP,
    output logic            rd_rt_s,
    output logic            imm_s,
    output logic            rt_imm_s,
    output logic            alu_mem_s,
    output logic [ST_W-1:0] state,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_EX_I   = 4'd3,
        S_EX_LS  = 4'd4,
        S_EX_BR  = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_LD  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // R-type funct decode: {valid, alu_op}
    function automatic logic [3:0] decode_r(input logic [5:0] fn);
        case (fn)
            FN_ADD:  decode_r = {1'b1, ALU_ADD};
            FN_SUB:  decode_r = {1'b1, ALU_SUB};
            FN_AND:  decode_r = {1'b1, ALU_AND};
            FN_OR:   decode_r = {1'b1, ALU_OR};
            FN_XOR:  decode_r = {1'b1, ALU_XOR};
            FN_NOR:  decode_r = {1'b1, ALU_NOR};
            FN_SLTU: decode_r = {1'b1, ALU_SLTU};
            FN_SLLV: decode_r = {1'b1, ALU_SLL};
            default: decode_r = {1'b0, ALU_ADD};
        endcase
    endfunction

    // I-type ALU opcode decode: {valid, alu_op}
    function automatic logic [3:0] decode_i(input logic [5:0] opc);
        case (opc)
            OP_ADDI:  decode_i = {1'b1, ALU_ADD};
            OP_ANDI:  decode_i = {1'b1, ALU_AND};
            OP_ORI:   decode_i = {1'b1, ALU_OR};
            OP_XORI:  decode_i = {1'b1, ALU_XOR};
            OP_SLTIU: decode_i = {1'b1, ALU_SLTU};
            default:  decode_i = {1'b0, ALU_ADD};
        endcase
    endfunction

    state_t     state_q, state_d;
    logic       of_q, of_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] r_dec;
    logic [3:0] i_dec;
    logic       ovf_trap;       // instruction whose write-back is suppressed on overflow
    logic       unused_inst;

    assign op          = Inst_code[31:26];
    assign funct       = Inst_code[5:0];
    assign r_dec       = decode_r(funct);
    assign i_dec       = decode_i(op);
    assign unused_inst = ^Inst_code[25:6];

    assign ovf_trap = ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)))
                    || (op == OP_ADDI);

    assign state = ST_W'(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            of_q    <= of_d;
        end
    end

    // Overflow is sampled only as the arithmetic EX states retire, so the
    // flag seen in WB belongs to the instruction being written back.
    always_comb begin
        of_d = of_q;
        if ((state_q == S_EX_R) || (state_q == S_EX_I)) begin
            of_d = OF;
        end
    end

    always_comb begin
        state_d   = S_IF;
        PC_Write  = 1'b0;
        PC_s      = 2'b00;
        IR_Write  = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = ALU_ADD;
        rd_rt_s   = 1'b0;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        alu_mem_s = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IF: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                PC_s     = 2'b00;
                state_d  = S_ID;
            end
            S_ID: begin
                if (op == OP_J) begin
                    PC_Write = 1'b1;
                    PC_s     = 2'b10;
                    state_d  = S_IF;
                end else if ((op == OP_RTYPE) && r_dec[3]) begin
                    state_d = S_EX_R;
                end else if (i_dec[3]) begin
                    state_d = S_EX_I;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = S_EX_LS;
                end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
                    state_d = S_EX_BR;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EX_R: begin
                ALU_OP   = r_dec[2:0];
                rt_imm_s = 1'b0;
                state_d  = S_WB_R;
            end
            S_EX_I: begin
                ALU_OP   = i_dec[2:0];
                rt_imm_s = 1'b1;
                imm_s    = (op == OP_ADDI) || (op == OP_SLTIU);
                state_d  = S_WB_I;
            end
            S_EX_LS: begin
                ALU_OP   = ALU_ADD;
                rt_imm_s = 1'b1;
                imm_s    = 1'b1;
                state_d  = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_EX_BR: begin
                ALU_OP   = ALU_SUB;
                rt_imm_s = 1'b0;
                imm_s    = 1'b1;
                PC_s     = 2'b01;
                PC_Write = (op == OP_BNE) ? ~ZF : ZF;
                state_d  = S_IF;
            end
            S_MEM_RD: begin
                state_d = S_WB_LD;
            end
            S_MEM_WR: begin
                Mem_Write = 1'b1;
                state_d   = S_IF;
            end
            S_WB_R: begin
                Write_Reg = ~(of_q & ovf_trap);
                rd_rt_s   = 1'b0;
                alu_mem_s = 1'b0;
                state_d   = S_IF;
            end
            S_WB_I: begin
                Write_Reg = ~(of_q & ovf_trap);
                rd_rt_s   = 1'b1;
                alu_mem_s = 1'b0;
                state_d   = S_IF;
            end
            S_WB_LD: begin
                Write_Reg = 1'b1;
                rd_rt_s   = 1'b1;
                alu_mem_s = 1'b1;
                state_d   = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        // Reset squashes any write in flight, whatever state we are in.
        if (rst) begin
            PC_Write  = 1'b0;
            IR_Write  = 1'b0;
            Write_Reg = 1'b0;
            Mem_Write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] Inst_code;
    logic        ZF;
    logic        OF;
    logic        PC_Write;
    logic [1:0]  PC_s;
    logic        IR_Write;
    logic        Write_Reg;
    logic        Mem_Write;
    logic [2:0]  ALU_OP;
    logic        rd_rt_s;
    logic        imm_s;
    logic        rt_imm_s;
    logic        alu_mem_s;
    logic [3:0]  state;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl #(.ST_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Inst_code (Inst_code),
        .ZF        (ZF),
        .OF        (OF),
        .PC_Write  (PC_Write),
        .PC_s      (PC_s),
        .IR_Write  (IR_Write),
        .Write_Reg (Write_Reg),
        .Mem_Write (Mem_Write),
        .ALU_OP    (ALU_OP),
        .rd_rt_s   (rd_rt_s),
        .imm_s     (imm_s),
        .rt_imm_s  (rt_imm_s),
        .alu_mem_s (alu_mem_s),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then settle 2 time units past the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {PC_Write, IR_Write, Write_Reg, Mem_Write}
    function automatic logic [31:0] en();
        return 32'({PC_Write, IR_Write, Write_Reg, Mem_Write});
    endfunction

    initial begin
        rst       = 1'b1;
        Inst_code = 32'h0;
        ZF        = 1'b0;
        OF        = 1'b0;

        // ---------------- reset held for two cycles
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_en", en(), 32'b0000);
        chk("rst_illegal", 32'(illegal), 32'd0);

        rst = 1'b0;
        Inst_code = 32'h00221820;               // add $3,$1,$2
        #1;
        chk("if_state", 32'(state), 32'd0);
        chk("if_en", en(), 32'b1100);
        chk("if_pcs", 32'(PC_s), 32'd0);

        // ---------------- add: 0,1,2,8
        tick();
        chk("add_id_state", 32'(state), 32'd1);
        chk("add_id_en", en(), 32'b0000);
        tick();
        OF = 1'b0;
        #1;
        chk("add_ex_state", 32'(state), 32'd2);
        chk("add_ex_alu", 32'(ALU_OP), 32'b100);
        chk("add_ex_rtimm", 32'(rt_imm_s), 32'd0);
        tick();
        chk("add_wb_state", 32'(state), 32'd8);
        chk("add_wb_en", en(), 32'b0010);
        chk("add_wb_rdrt", 32'(rd_rt_s), 32'd0);
        chk("add_wb_aluMem", 32'(alu_mem_s), 32'd0);
        tick();
        chk("add_next_if", 32'(state), 32'd0);

        // ---------------- sub with overflow: write-back suppressed
        Inst_code = 32'h00221822;               // sub $3,$1,$2
        tick();
        tick();
        OF = 1'b1;
        #1;
        chk("sub_ex_alu", 32'(ALU_OP), 32'b101);
        tick();
        OF = 1'b0;
        #1;
        chk("sub_ovf_wb_state", 32'(state), 32'd8);
        chk("sub_ovf_wb_en", en(), 32'b0000);
        tick();

        // ---------------- nor with OF=1: overflow ignored
        Inst_code = 32'h00221827;               // nor $3,$1,$2
        tick();
        tick();
        OF = 1'b1;
        #1;
        chk("nor_ex_alu", 32'(ALU_OP), 32'b011);
        tick();
        OF = 1'b0;
        #1;
        chk("nor_wb_en", en(), 32'b0010);
        tick();

        // ---------------- lw: 0,1,4,6,10
        Inst_code = 32'h8C050008;               // lw $5,8($0)
        chk("lw_if", 32'(state), 32'd0);
        tick();
        chk("lw_id", 32'(state), 32'd1);
        tick();
        chk("lw_ex_state", 32'(state), 32'd4);
        chk("lw_ex_sel", 32'({ALU_OP, rt_imm_s, imm_s}), 32'b10011);
        tick();
        chk("lw_mem_state", 32'(state), 32'd6);
        chk("lw_mem_en", en(), 32'b0000);
        tick();
        chk("lw_wb_state", 32'(state), 32'd10);
        chk("lw_wb_en", en(), 32'b0010);
        chk("lw_wb_sel", 32'({alu_mem_s, rd_rt_s}), 32'b11);
        tick();
        chk("lw_done", 32'(state), 32'd0);

        // ---------------- sw: 0,1,4,7
        Inst_code = 32'hAC050008;               // sw $5,8($0)
        tick();
        tick();
        chk("sw_ex_state", 32'(state), 32'd4);
        tick();
        chk("sw_mem_state", 32'(state), 32'd7);
        chk("sw_mem_en", en(), 32'b0001);
        tick();
        chk("sw_done", 32'(state), 32'd0);

        // ---------------- beq taken: 0,1,5
        Inst_code = 32'h10210004;               // beq $1,$1,+4
        tick();
        tick();
        ZF = 1'b1;
        #1;
        chk("beq_state", 32'(state), 32'd5);
        chk("beq_en", en(), 32'b1000);
        chk("beq_pcs", 32'(PC_s), 32'b01);
        chk("beq_alu", 32'(ALU_OP), 32'b101);
        ZF = 1'b0;
        #1;
        chk("beq_nt_en", en(), 32'b0000);
        tick();
        chk("beq_done", 32'(state), 32'd0);

        // ---------------- bne with ZF=1 not taken, ZF=0 taken
        Inst_code = 32'h14210004;               // bne $1,$1,+4
        tick();
        tick();
        ZF = 1'b1;
        #1;
        chk("bne_zf1_en", en(), 32'b0000);
        ZF = 1'b0;
        #1;
        chk("bne_zf0_en", en(), 32'b1000);
        tick();

        // ---------------- addi with OF=1 then OF=0
        Inst_code = 32'h20220005;               // addi $2,$1,5
        tick();
        tick();
        OF = 1'b1;
        #1;
        chk("addi_ex_state", 32'(state), 32'd3);
        chk("addi_ex_sel", 32'({ALU_OP, rt_imm_s, imm_s}), 32'b10011);
        tick();
        OF = 1'b0;
        #1;
        chk("addi_ovf_state", 32'(state), 32'd9);
        chk("addi_ovf_en", en(), 32'b0000);
        chk("addi_ovf_rdrt", 32'(rd_rt_s), 32'd1);
        tick();
        tick();
        tick();
        tick();
        chk("addi_ok_state", 32'(state), 32'd9);
        chk("addi_ok_en", en(), 32'b0010);
        tick();

        // ---------------- andi: zero-extend, AND, overflow ignored
        Inst_code = 32'h30220005;               // andi $2,$1,5
        tick();
        tick();
        OF = 1'b1;
        #1;
        chk("andi_ex_sel", 32'({ALU_OP, rt_imm_s, imm_s}), 32'b00010);
        tick();
        OF = 1'b0;
        #1;
        chk("andi_wb_en", en(), 32'b0010);
        tick();

        // ---------------- illegal opcode 111111
        Inst_code = 32'hFC000000;
        tick();
        chk("ill_op_illegal", 32'(illegal), 32'd1);
        chk("ill_op_en", en(), 32'b0000);
        tick();
        chk("ill_op_back_if", 32'(state), 32'd0);
        chk("ill_op_pulse_end", 32'(illegal), 32'd0);

        // ---------------- illegal R-type funct
        Inst_code = 32'h00000001;
        tick();
        chk("ill_fn_illegal", 32'(illegal), 32'd1);
        tick();
        chk("ill_fn_back_if", 32'(state), 32'd0);

        // ---------------- j 0x0000040: two cycles
        Inst_code = 32'h08000040;
        tick();
        chk("j_id_en", en(), 32'b1000);
        chk("j_id_pcs", 32'(PC_s), 32'b10);
        tick();
        chk("j_done", 32'(state), 32'd0);

        // ---------------- mid-instruction reset squashes the pending write
        Inst_code = 32'h00221820;
        tick();
        tick();
        tick();
        chk("mid_wb_state", 32'(state), 32'd8);
        rst = 1'b1;
        #1;
        chk("mid_rst_wb_en", en(), 32'b0000);
        tick();
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_if_en", en(), 32'b0000);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rel_state", 32'(state), 32'd0);
        chk("mid_rel_en", en(), 32'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
